minmax_window_tracker: RTL
==========================

Name: minmax_window_tracker

Overview:
Parametrised successor to the single-stream min/max controller. Tracks minimum and maximum of a sample stream with a valid qualifier, in one of two run-time-selectable modes:
- cumulative: all samples since reset or clear.
- sliding window: the last DEPTH samples.
Compare is signed or unsigned by parameter. Sits between the sample source and downstream control logic, replacing the fixed 32-bit min/max path.

Parameters:
WIDTH, 32, sample and result width in bits
DEPTH, 4, sliding-window length in samples (>= 2)
SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare
CNT_W, 16, width of the saturating accepted-sample counter

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low (rst=0 at a rising edge resets)
in_valid  input  1  sample qualifier; sample accepted at any edge with in_valid=1
in_data  input  WIDTH  sample value
clear  input  1  synchronous soft clear of all history
mode  input  1  0 = cumulative, 1 = sliding window
min_out  output  WIDTH  registered minimum for the selected mode
max_out  output  WIDTH  registered maximum for the selected mode
out_valid  output  1  1 when at least one sample is held since reset/clear
sample_count  output  CNT_W  accepted samples since reset/clear, saturating

Behaviour:
- Reset (rst=0 at edge):
  - All window entries marked empty; cumulative min/max registers = 0.
  - min_out = 0, max_out = 0, out_valid = 0, sample_count = 0.
  - Reset overrides clear and in_valid.
- clear=1 (rst=1):
  - Same effect as reset on all state and outputs.
  - Concurrent in_valid sample is dropped; clear has priority.
- Accept (in_valid=1, clear=0, rst=1):
  - Window is a DEPTH-entry shift register with per-entry valid bits; the new sample enters entry 0 and the oldest is discarded.
  - Cumulative regs:
    - First sample after reset/clear loads both min and max.
    - Later samples replace min if strictly less and max if strictly greater.
    - Ties leave the registers unchanged.
  - sample_count increments, saturating at 2^CNT_W-1.
- Latency: 1 cycle. Outputs after edge k include the sample accepted at edge k.
- in_valid=0: window, cumulative state and count hold.
- Output recompute:
  - min_out/max_out are recomputed every edge from the post-update state and the current mode.
  - A mode change with no sample takes effect at the next edge.
- Window mode result:
  - min/max over valid window entries only.
  - Before DEPTH samples have arrived, this covers only those received.
- Compare:
  - SIGNED=1: in_data treated as two's complement.
  - SIGNED=0: unsigned.
  - No width extension; outputs are exact sample values.
- out_valid rises on the edge accepting the first sample; it falls only on reset or clear.
- No backpressure: every valid sample is accepted.

Decomposition:
- Package minmax_pkg:
  - mode encoding constants MODE_CUM=0, MODE_WIN=1.
  - functions lt_sel / gt_sel(a, b, signed_en) for the parametrised compare.
- Sub-module minmax_window_reduce:
  - Combinational reduction tree over DEPTH entries with valid mask.
  - Produces window min and max.
  - Parameters WIDTH, DEPTH, SIGNED.
- Top level holds the shift register, cumulative regs, counter and output regs.

Test Plan:
- Cumulative, defaults: rst=0 for 2 cycles, then rst=1; samples 1, 2, -1, 4, one per cycle, mode=0.
  - (min,max) after each edge: (1,1), (1,2), (-1,2), (-1,4).
  - out_valid=1 from the first sample; sample_count=4.
- Window mode, DEPTH=2, samples 1, 2, -1, 4, 5, mode=1:
  - (1,1), (1,2), (-1,2), (-1,4), (4,5).
  - Then mode=0 with in_valid=0: next edge gives (-1,5). Mode=1 again gives (4,5).
- SIGNED=0, samples 1, 2, 0xFFFFFFFF, 4, mode=0: final min=1, max=0xFFFFFFFF.
- Bubbles: samples 3, (in_valid=0 for 3 cycles), 7.
  - Outputs hold (3,3) and count=1 during the gap.
  - After 7: (3,7), count=2.
- Clear/reset:
  - After 5, 9: assert clear with in_valid=1, in_data=1. Next edge: out_valid=0, min=max=0, count=0, sample 1 dropped.
  - Then sample 6 gives (6,6).
  - rst=0 mid-stream: same all-zero result.
- Saturation, CNT_W=3: 9 consecutive samples. sample_count reaches 7 and stays 7; min/max still track.

Source files
------------

// File: rtl/minmax_pkg.sv
// Shared mode encodings and the run-time-selectable signed/unsigned compare.
package minmax_pkg;
  localparam logic MODE_CUM = 1'b0;
  localparam logic MODE_WIN = 1'b1;

  // Callers widen operands to CMP_W: sign-extend for signed, zero-extend otherwise.
  localparam int CMP_W = 64;

  function automatic logic lt_sel(input logic [CMP_W-1:0] a, input logic [CMP_W-1:0] b,
                                  input logic signed_en);
    if (signed_en) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  function automatic logic gt_sel(input logic [CMP_W-1:0] a, input logic [CMP_W-1:0] b,
                                  input logic signed_en);
    if (signed_en) return $signed(a) > $signed(b);
    return a > b;
  endfunction
endpackage

// File: rtl/minmax_window_reduce.sv
// Combinational min/max over the valid entries of the sample window.
module minmax_window_reduce
  import minmax_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int SIGNED = 1
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] i_ent,
  input  logic [DEPTH-1:0]            i_vld,
  output logic [WIDTH-1:0]            o_min,
  output logic [WIDTH-1:0]            o_max
);
  localparam logic SGN = (SIGNED != 0);

  function automatic logic [CMP_W-1:0] ext(input logic [WIDTH-1:0] v);
    if (SGN) return CMP_W'($signed(v));
    return CMP_W'(v);
  endfunction

  logic w_any;

  // An empty window reports zero for both results.
  always_comb begin
    o_min = '0;
    o_max = '0;
    w_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_vld[i]) begin
        if (!w_any || lt_sel(ext(i_ent[i]), ext(o_min), SGN)) o_min = i_ent[i];
        if (!w_any || gt_sel(ext(i_ent[i]), ext(o_max), SGN)) o_max = i_ent[i];
        w_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/minmax_window_tracker.sv
// Cumulative or sliding-window min/max tracker with saturating sample count.
module minmax_window_tracker
  import minmax_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int SIGNED = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  input  logic             mode,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out,
  output logic             out_valid,
  output logic [CNT_W-1:0] sample_count
);
  localparam logic SGN = (SIGNED != 0);

  function automatic logic [CMP_W-1:0] ext(input logic [WIDTH-1:0] v);
    if (SGN) return CMP_W'($signed(v));
    return CMP_W'(v);
  endfunction

  logic [DEPTH-1:0][WIDTH-1:0] r_win, w_win_nxt;
  logic [DEPTH-1:0]            r_wv, w_wv_nxt;
  logic [WIDTH-1:0]            r_cmin, r_cmax, w_cmin_nxt, w_cmax_nxt;
  logic [WIDTH-1:0]            r_min, r_max, w_wmin, w_wmax;
  logic [CNT_W-1:0]            r_cnt, w_cnt_nxt;
  logic                        r_ov, w_ov_nxt;

  // Next state first, so the registered outputs already include this edge's sample.
  always_comb begin
    w_win_nxt  = r_win;
    w_wv_nxt   = r_wv;
    w_cmin_nxt = r_cmin;
    w_cmax_nxt = r_cmax;
    w_cnt_nxt  = r_cnt;
    w_ov_nxt   = r_ov;
    if (clear) begin
      w_win_nxt  = '0;
      w_wv_nxt   = '0;
      w_cmin_nxt = '0;
      w_cmax_nxt = '0;
      w_cnt_nxt  = '0;
      w_ov_nxt   = 1'b0;
    end else if (in_valid) begin
      w_win_nxt = {r_win[DEPTH-2:0], in_data};
      w_wv_nxt  = {r_wv[DEPTH-2:0], 1'b1};
      if (!r_ov || lt_sel(ext(in_data), ext(r_cmin), SGN)) w_cmin_nxt = in_data;
      if (!r_ov || gt_sel(ext(in_data), ext(r_cmax), SGN)) w_cmax_nxt = in_data;
      w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
      w_ov_nxt  = 1'b1;
    end
  end

  minmax_window_reduce #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .SIGNED(SIGNED)
  ) u_reduce (
    .i_ent(w_win_nxt),
    .i_vld(w_wv_nxt),
    .o_min(w_wmin),
    .o_max(w_wmax)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_win  <= '0;
      r_wv   <= '0;
      r_cmin <= '0;
      r_cmax <= '0;
      r_cnt  <= '0;
      r_ov   <= 1'b0;
      r_min  <= '0;
      r_max  <= '0;
    end else begin
      r_win  <= w_win_nxt;
      r_wv   <= w_wv_nxt;
      r_cmin <= w_cmin_nxt;
      r_cmax <= w_cmax_nxt;
      r_cnt  <= w_cnt_nxt;
      r_ov   <= w_ov_nxt;
      r_min  <= (mode == MODE_WIN) ? w_wmin : w_cmin_nxt;
      r_max  <= (mode == MODE_WIN) ? w_wmax : w_cmax_nxt;
    end
  end

  assign min_out      = r_min;
  assign max_out      = r_max;
  assign out_valid    = r_ov;
  assign sample_count = r_cnt;
endmodule
